// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM PCM packer.
//   PCM_W          default PCM sample width
//   PDM_MODE_*     channel-mode encodings of cfg_ch_mode_i
//   ch_count()     number of interleaved channels for a mode
//   pcm_word_t     FIFO entry: packed 32-bit word plus the channel of its low half
package pdm_pkg;

    localparam int PCM_W = 16;

    localparam logic [1:0] PDM_MODE_1CH     = 2'd0;
    localparam logic [1:0] PDM_MODE_2CH_RF  = 2'd1;
    localparam logic [1:0] PDM_MODE_2CH_SEP = 2'd2;
    localparam logic [1:0] PDM_MODE_4CH     = 2'd3;

    function automatic logic [2:0] ch_count(input logic [1:0] mode);
        case (mode)
            PDM_MODE_1CH:     ch_count = 3'd1;
            PDM_MODE_2CH_RF:  ch_count = 3'd2;
            PDM_MODE_2CH_SEP: ch_count = 3'd2;
            default:          ch_count = 3'd4;
        endcase
    endfunction

    typedef struct packed {
        logic [2*PCM_W-1:0] data;
        logic [1:0]         ch;
    } pcm_word_t;

endpackage

// File: rtl/pcm_sync_fifo.sv
// Single-clock FIFO of pcm_word_t entries.
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   flush          synchronous empty (pointers to zero)
//   push, wdata    write request; ignored when full unless a pop happens the same cycle
//   pop            advance the head; ignored when empty
//   rdata          head entry, read combinationally (undefined content when empty)
//   full, empty    status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pcm_sync_fifo
    import pdm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      flush,
    input  logic      push,
    input  pcm_word_t wdata,
    input  logic      pop,
    output pcm_word_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    pcm_word_t     mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush && do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pdm_pcm_packer.sv
// Packs the channel-interleaved PCM stream from the CIC decimator into
// 32-bit words tagged with the channel of their low-half sample, and queues
// them towards the uDMA RX stream.
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   cfg_en_i           enable; low flushes FIFO, counter and half-register
//   cfg_ch_mode_i      channel mode (PDM_MODE_*)
//   cfg_pack_i         1: two samples per word, 0: one sample per word
//   cfg_sign_ext_i     unpacked upper half: 1 sign-extend, 0 zero-extend
//   cfg_clr_i          clears overflow_o
//   pcm_data_i/valid_i sample stream, no backpressure
//   data_o, ch_o       FIFO head (0 when empty)
//   valid_o, ready_i   output handshake
//   overflow_o         sticky: a completed word found the FIFO full
module pdm_pcm_packer
    import pdm_pkg::*;
#(
    parameter int PCM_WIDTH  = PCM_W,   // must match pdm_pkg::PCM_W (word struct width)
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   cfg_en_i,
    input  logic [1:0]             cfg_ch_mode_i,
    input  logic                   cfg_pack_i,
    input  logic                   cfg_sign_ext_i,
    input  logic                   cfg_clr_i,
    input  logic [PCM_WIDTH-1:0]   pcm_data_i,
    input  logic                   pcm_valid_i,
    output logic [2*PCM_WIDTH-1:0] data_o,
    output logic [1:0]             ch_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overflow_o
);

    logic [1:0]           ch_cnt;
    logic [2:0]           n_ch;
    logic                 half_vld;
    logic [PCM_WIDTH-1:0] half_data;
    logic [1:0]           half_ch;

    logic                 sample;
    logic                 word_vld;
    pcm_word_t            word;
    pcm_word_t            head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 accept;

    assign n_ch   = ch_count(cfg_ch_mode_i);
    assign sample = cfg_en_i & pcm_valid_i;

    // Word formation: unpacked words complete on every sample, packed words
    // on the sample that finds the half-register occupied.
    always_comb begin
        word     = '0;
        word_vld = 1'b0;
        if (sample) begin
            if (!cfg_pack_i) begin
                word_vld  = 1'b1;
                word.data = {(cfg_sign_ext_i ? {PCM_WIDTH{pcm_data_i[PCM_WIDTH-1]}}
                                             : {PCM_WIDTH{1'b0}}), pcm_data_i};
                word.ch   = ch_cnt;
            end else if (half_vld) begin
                word_vld  = 1'b1;
                word.data = {pcm_data_i, half_data};
                word.ch   = half_ch;
            end
        end
    end

    assign pop    = valid_o & ready_i;
    assign accept = ~fifo_full | pop;

    // Channel counter and pack half-register. The >= test also recovers a
    // counter left out of range by a mode change while enabled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ch_cnt    <= '0;
            half_vld  <= 1'b0;
            half_data <= '0;
            half_ch   <= '0;
        end else if (!cfg_en_i) begin
            ch_cnt    <= '0;
            half_vld  <= 1'b0;
        end else if (sample) begin
            if ({1'b0, ch_cnt} >= n_ch - 3'd1) ch_cnt <= '0;
            else                               ch_cnt <= ch_cnt + 2'd1;
            if (cfg_pack_i && !half_vld) begin
                half_vld  <= 1'b1;
                half_data <= pcm_data_i;
                half_ch   <= ch_cnt;
            end else begin
                half_vld  <= 1'b0;
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                   overflow_o <= 1'b0;
        else if (word_vld && !accept)  overflow_o <= 1'b1;
        else if (cfg_clr_i || !cfg_en_i) overflow_o <= 1'b0;
    end

    pcm_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .flush  (~cfg_en_i),
        .push   (word_vld & accept),
        .wdata  (word),
        .pop    (pop),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign valid_o = ~fifo_empty;
    assign data_o  = fifo_empty ? '0 : head.data;
    assign ch_o    = fifo_empty ? '0 : head.ch;

endmodule
